// File: rtl/bus_snoop_responder.sv
// Bus-side snoop responder standing in for the remote caches: answers HIT/HITM/NOHIT
// and tracks remote MESI line states. Define BUS_STATS_EN to enable the result counters.
module bus_snoop_responder #(
    parameter int unsigned ENTRIES  = 8,
    parameter int unsigned RESP_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic        pre_valid,
    input  logic [31:0] pre_addr,
    input  logic [1:0]  pre_mesi,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [1:0]  resp_result,
    output logic        hit,
    output logic        hitM,
    output logic        bad_op,
    output logic [15:0] hit_cnt,
    output logic [15:0] hitm_cnt,
    output logic [15:0] nohit_cnt
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned LINE_W = 26;
    localparam int unsigned LAT_W  = (RESP_LAT > 2) ? $clog2(RESP_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = (RESP_LAT > 2) ? LAT_W'(RESP_LAT - 2) : '0;

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RFO   = 3'd4;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    localparam logic [1:0] RES_HIT   = 2'b00;
    localparam logic [1:0] RES_HITM  = 2'b01;
    localparam logic [1:0] RES_NOHIT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [2:0]         op_q, op_d;
    logic [LINE_W-1:0]  line_lat_q, line_lat_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [1:0]         res_q, res_d;
    logic               bad_q, bad_d;
    logic               resp_valid_q, resp_valid_d;
    logic               hit_q, hit_d;
    logic               hitm_q, hitm_d;
    logic               bad_op_q, bad_op_d;

    logic [LINE_W-1:0]  line_q [ENTRIES];
    logic [1:0]         mesi_q [ENTRIES];

    logic               wr_en_c;
    logic [IDX_W-1:0]   wr_idx_c;
    logic [LINE_W-1:0]  wr_line_c;
    logic [1:0]         wr_mesi_c;

    logic               lk_hit_c;
    logic [IDX_W-1:0]   lk_idx_c;
    logic [1:0]         lk_mesi_c;
    logic               pre_hit_c;
    logic [IDX_W-1:0]   pre_idx_c;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[5:0], pre_addr[5:0]};

    // Fully associative match of the latched request line and the preload line
    always_comb begin
        lk_hit_c  = 1'b0;
        lk_idx_c  = '0;
        pre_hit_c = 1'b0;
        pre_idx_c = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (mesi_q[i] != MESI_I && line_q[i] == line_lat_q) begin
                lk_hit_c = 1'b1;
                lk_idx_c = IDX_W'(i);
            end
            if (mesi_q[i] != MESI_I && line_q[i] == pre_addr[31:6]) begin
                pre_hit_c = 1'b1;
                pre_idx_c = IDX_W'(i);
            end
        end
        lk_mesi_c = mesi_q[lk_idx_c];
    end

    // Next-state, table update and registered-output decode
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        op_d       = op_q;
        line_lat_d = line_lat_q;
        lat_d      = lat_q;
        res_d      = res_q;
        bad_d      = bad_q;
        wr_en_c    = 1'b0;
        wr_idx_c   = lk_idx_c;
        wr_line_c  = line_q[lk_idx_c];
        wr_mesi_c  = MESI_I;

        case (state_q)
            ST_IDLE: begin
                if (pre_valid) begin
                    wr_en_c   = 1'b1;
                    wr_line_c = pre_addr[31:6];
                    wr_mesi_c = pre_mesi;
                    if (pre_hit_c) begin
                        wr_idx_c = pre_idx_c;
                    end else begin
                        wr_idx_c = ptr_q;
                        ptr_d    = ptr_q + IDX_W'(1);
                    end
                end else if (req_valid) begin
                    op_d       = req_op;
                    line_lat_d = req_addr[31:6];
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                res_d = RES_NOHIT;
                bad_d = 1'b0;
                case (op_q)
                    OP_READ: begin
                        if (lk_hit_c) begin
                            res_d     = (lk_mesi_c == MESI_M) ? RES_HITM : RES_HIT;
                            wr_en_c   = 1'b1;
                            wr_mesi_c = MESI_S;
                        end
                    end
                    OP_WRITE: begin
                        res_d = RES_NOHIT;
                    end
                    OP_INV: begin
                        if (lk_hit_c && lk_mesi_c == MESI_S) begin
                            res_d     = RES_HIT;
                            wr_en_c   = 1'b1;
                            wr_mesi_c = MESI_I;
                        end
                    end
                    OP_RFO: begin
                        if (lk_hit_c) begin
                            res_d     = (lk_mesi_c == MESI_M) ? RES_HITM : RES_HIT;
                            wr_en_c   = 1'b1;
                            wr_mesi_c = MESI_I;
                        end
                    end
                    default: bad_d = 1'b1;
                endcase
                if (RESP_LAT == 1) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        resp_valid_d = (state_d == ST_RESP);
        hit_d        = resp_valid_d && (res_d == RES_HIT);
        hitm_d       = resp_valid_d && (res_d == RES_HITM);
        bad_op_d     = resp_valid_d && bad_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            op_q         <= '0;
            line_lat_q   <= '0;
            lat_q        <= '0;
            res_q        <= RES_NOHIT;
            bad_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            hitm_q       <= 1'b0;
            bad_op_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            line_lat_q   <= line_lat_d;
            lat_q        <= lat_d;
            res_q        <= res_d;
            bad_q        <= bad_d;
            resp_valid_q <= resp_valid_d;
            hit_q        <= hit_d;
            hitm_q       <= hitm_d;
            bad_op_q     <= bad_op_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                line_q[i] <= '0;
                mesi_q[i] <= MESI_I;
            end
        end else if (wr_en_c) begin
            line_q[wr_idx_c] <= wr_line_c;
            mesi_q[wr_idx_c] <= wr_mesi_c;
        end
    end

    // Preload blocks acceptance combinationally so it wins over a same-cycle request
    assign req_ready   = (state_q == ST_IDLE) && !pre_valid;
    assign resp_valid  = resp_valid_q;
    assign resp_result = res_q;
    assign hit         = hit_q;
    assign hitM        = hitm_q;
    assign bad_op      = bad_op_q;

`ifdef BUS_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] hitm_cnt_q, hitm_cnt_d;
    logic [15:0] nohit_cnt_q, nohit_cnt_d;

    // Saturating per-result counters, bumped on the response handshake
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        hitm_cnt_d  = hitm_cnt_q;
        nohit_cnt_d = nohit_cnt_q;
        if (resp_valid_q && resp_ready) begin
            case (res_q)
                RES_HIT:  if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                RES_HITM: if (hitm_cnt_q != 16'hFFFF) hitm_cnt_d = hitm_cnt_q + 16'd1;
                default:  if (nohit_cnt_q != 16'hFFFF) nohit_cnt_d = nohit_cnt_q + 16'd1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q   <= '0;
            hitm_cnt_q  <= '0;
            nohit_cnt_q <= '0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            hitm_cnt_q  <= hitm_cnt_d;
            nohit_cnt_q <= nohit_cnt_d;
        end
    end

    assign hit_cnt   = hit_cnt_q;
    assign hitm_cnt  = hitm_cnt_q;
    assign nohit_cnt = nohit_cnt_q;
`else
    assign hit_cnt   = '0;
    assign hitm_cnt  = '0;
    assign nohit_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_snoop_responder.sv
// Directed self-checking bench for bus_snoop_responder (hand-computed expected results).
module tb_bus_snoop_responder;

    localparam int unsigned ENTRIES  = 8;
    localparam int unsigned RESP_LAT = 2;

    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INV   = 3'd3;
    localparam logic [2:0] OP_RFO   = 3'd4;

    localparam logic [1:0] M_S = 2'b01;
    localparam logic [1:0] M_E = 2'b10;
    localparam logic [1:0] M_M = 2'b11;

    localparam logic [1:0] R_HIT   = 2'b00;
    localparam logic [1:0] R_HITM  = 2'b01;
    localparam logic [1:0] R_NOHIT = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic        pre_valid;
    logic [31:0] pre_addr;
    logic [1:0]  pre_mesi;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_result;
    logic        hit;
    logic        hitM;
    logic        bad_op;
    logic [15:0] hit_cnt;
    logic [15:0] hitm_cnt;
    logic [15:0] nohit_cnt;

    int vecs = 0;
    int errs = 0;
    int exp_hit = 0;
    int exp_hitm = 0;
    int exp_nohit = 0;

    bus_snoop_responder #(.ENTRIES(ENTRIES), .RESP_LAT(RESP_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .pre_valid(pre_valid), .pre_addr(pre_addr), .pre_mesi(pre_mesi),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .hit(hit), .hitM(hitM), .bad_op(bad_op),
        .hit_cnt(hit_cnt), .hitm_cnt(hitm_cnt), .nohit_cnt(nohit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [1:0] m);
        @(negedge clk);
        pre_valid = 1'b1;
        pre_addr  = a;
        pre_mesi  = m;
        #1 chk("pre_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        pre_valid = 1'b0;
    endtask

    // Issue one op, check latency, result flags (held for 'hold' stalled cycles) and release
    task automatic bus_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [1:0] exp_r, input logic exp_bad, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_busy"}, 32'(req_ready), 32'd0);
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(RESP_LAT));
        for (int i = 0; i <= hold; i++) begin
            chk({tag, "_vld"}, 32'(resp_valid), 32'd1);
            chk({tag, "_res"}, 32'(resp_result), 32'(exp_r));
            chk({tag, "_hit"}, 32'(hit), 32'(exp_r == R_HIT));
            chk({tag, "_hitM"}, 32'(hitM), 32'(exp_r == R_HITM));
            chk({tag, "_bad"}, 32'(bad_op), 32'(exp_bad));
            if (i < hold) begin
                chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
                @(negedge clk);
            end
        end
        resp_ready = 1'b1;
`ifdef BUS_STATS_EN
        case (exp_r)
            R_HIT:   exp_hit++;
            R_HITM:  exp_hitm++;
            default: exp_nohit++;
        endcase
`endif
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_drop"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(exp_hit));
        chk({tag, "_hitm_cnt"}, 32'(hitm_cnt), 32'(exp_hitm));
        chk({tag, "_nohit_cnt"}, 32'(nohit_cnt), 32'(exp_nohit));
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = '0;
        req_addr   = '0;
        pre_valid  = 1'b0;
        pre_addr   = '0;
        pre_mesi   = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_result", 32'(resp_result), 32'(R_NOHIT));
        chk("rst_flags", 32'({hit, hitM, bad_op}), 32'd0);
        chk_cnts("rst");
        rst = 1'b0;

        // Reset while a response is pending in WAIT
        preload(32'h984D_E132, M_M);
        bus_op("pre_rst", OP_READ, 32'h0000_1000, R_NOHIT, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_READ;
        req_addr  = 32'h984D_E100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        exp_hit   = 0;
        exp_hitm  = 0;
        exp_nohit = 0;
        chk_cnts("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_ready", 32'(req_ready), 32'd1);
        chk("postrst_valid", 32'(resp_valid), 32'd0);
        bus_op("postrst_rd", OP_READ, 32'h984D_E100, R_NOHIT, 1'b0, 0);

        // M line: READ gives HITM then the line is shared
        preload(32'h984D_E132, M_M);
        bus_op("m_rd1", OP_READ, 32'h984D_E100, R_HITM, 1'b0, 0);
        bus_op("m_rd2", OP_READ, 32'h984D_E100, R_HIT, 1'b0, 0);

        // E line: RFO hits and invalidates, so INVALIDATE then misses
        preload(32'h116D_E12F, M_E);
        bus_op("e_rfo", OP_RFO, 32'h116D_E12F, R_HIT, 1'b0, 0);
        bus_op("e_inv", OP_INV, 32'h116D_E12F, R_NOHIT, 1'b0, 0);

        // Backpressure on a shared-line hit
        preload(32'h0ABC_0040, M_S);
        bus_op("bp", OP_READ, 32'h0ABC_0040, R_HIT, 1'b0, 5);
        bus_op("s_inv", OP_INV, 32'h0ABC_0040, R_HIT, 1'b0, 0);
        bus_op("s_inv2", OP_READ, 32'h0ABC_0040, R_NOHIT, 1'b0, 0);

        // Fill ENTRIES+1 lines; the victim pointer wraps onto the first one
        for (int i = 0; i <= int'(ENTRIES); i++) begin
            preload(32'h5000_0000 + 32'(i * 64), M_S);
        end
        bus_op("fill0", OP_READ, 32'h5000_0000, R_NOHIT, 1'b0, 0);
        for (int i = 1; i <= int'(ENTRIES); i++) begin
            bus_op($sformatf("fill%0d", i), OP_READ, 32'h5000_0000 + 32'(i * 64), R_HIT, 1'b0, 0);
        end

        bus_op("wr", OP_WRITE, 32'h5000_0040, R_NOHIT, 1'b0, 0);
        bus_op("wr_rd", OP_READ, 32'h5000_0040, R_HIT, 1'b0, 0);
        bus_op("op7", 3'd7, 32'h5000_0040, R_NOHIT, 1'b1, 0);
        bus_op("op0", 3'd0, 32'h5000_0080, R_NOHIT, 1'b1, 0);
        bus_op("op_rd", OP_READ, 32'h5000_0080, R_HIT, 1'b0, 0);

        chk_cnts("final");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
